// File: rtl/brownout_pkg.sv
// Shared definitions for the brownout handler.
// Holds the FSM state encodings, the default parameter values and a helper
// used to size the internal counters.
package brownout_pkg;

  localparam logic [2:0] ST_NORMAL   = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_SAVE     = 3'd2;
  localparam logic [2:0] ST_SHUTDOWN = 3'd3;
  localparam logic [2:0] ST_RESTART  = 3'd4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_RECOVER_CYCLES  = 16;
  localparam int unsigned DEF_SAVE_TIMEOUT    = 32;
  localparam int unsigned DEF_CNT_W           = 8;

  // Largest of three values; sizes the shared counter width.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/brownout_handler_run_counter.sv
// run_counter: consecutive-sample counter with clear, enable and a
// terminal-count compare.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - clears the run count
//   en         - counts one qualifying sample this cycle
//   limit      - terminal count
//   hit_c      - combinational: this sample completes the run (count+1 >= limit)
module run_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         hit_c
);

  logic [W-1:0] count;

  // The run is complete on the sample that brings the count to the limit.
  assign hit_c = en && ((count + W'(1)) >= limit);

  // Counter restarts after a completed run so the next run begins from zero.
  always_ff @(posedge clk) begin
    if (rst || clr || hit_c) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/brownout_handler.sv
// brownout_handler: debounces the brownout flag, requests a state save with a
// timeout-bounded req/ack handshake, holds the system gated and in reset, and
// releases it after a clean-supply recovery window.
// Optional feature macro: BROWNOUT_EVENT_CNT_EN (saturating event counter).
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   brownout_in  - brownout flag from the detector
//   save_ack     - system has finished saving state
//   save_req     - state save request (SAVE)
//   power_gate   - load disconnected (SHUTDOWN)
//   sys_reset    - system held in reset (SHUTDOWN, RESTART)
//   save_timeout - sticky: a SAVE ended by timeout
//   state        - FSM state, for debug
//   event_count  - saturating count of SAVE entries
module brownout_handler
  import brownout_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RECOVER_CYCLES  = DEF_RECOVER_CYCLES,
  parameter int unsigned SAVE_TIMEOUT    = DEF_SAVE_TIMEOUT,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             brownout_in,
  input  logic             save_ack,
  output logic             save_req,
  output logic             power_gate,
  output logic             sys_reset,
  output logic             save_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned MAX_P = max3(DEBOUNCE_CYCLES, RECOVER_CYCLES, SAVE_TIMEOUT);
  localparam int unsigned CW    = $clog2(MAX_P) + 1;

  logic [2:0]    state_nxt;
  logic          save_req_nxt;
  logic          power_gate_nxt;
  logic          sys_reset_nxt;
  logic          save_timeout_nxt;
  logic          deb_en;
  logic          deb_hit_c;
  logic          rec_en;
  logic          rec_hit_c;
  logic          tmo_hit_c;
  logic [CW-1:0] save_timer;

  // Debounce run: high samples while NORMAL/DEBOUNCE; any low sample clears.
  assign deb_en = brownout_in && ((state == ST_NORMAL) || (state == ST_DEBOUNCE));

  run_counter #(.W(CW)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .clr   (!deb_en),
    .en    (deb_en),
    .limit (CW'(DEBOUNCE_CYCLES)),
    .hit_c (deb_hit_c)
  );

  // Recovery run: low samples while SHUTDOWN; any high sample clears.
  assign rec_en = !brownout_in && (state == ST_SHUTDOWN);

  run_counter #(.W(CW)) u_recover (
    .clk   (clk),
    .rst   (rst),
    .clr   (!rec_en),
    .en    (rec_en),
    .limit (CW'(RECOVER_CYCLES)),
    .hit_c (rec_hit_c)
  );

  // This edge is the SAVE_TIMEOUT-th one spent in SAVE.
  assign tmo_hit_c = (save_timer + CW'(1)) == CW'(SAVE_TIMEOUT);

  // SAVE timer: zero on entry, counts every edge that stays in SAVE.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_SAVE) || (state_nxt != ST_SAVE)) begin
      save_timer <= '0;
    end else begin
      save_timer <= save_timer + CW'(1);
    end
  end

  // Next state and next (registered) outputs, decoded from the next state.
  always_comb begin
    state_nxt        = state;
    save_timeout_nxt = save_timeout;
    case (state)
      ST_NORMAL: begin
        if (brownout_in) state_nxt = deb_hit_c ? ST_SAVE : ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!brownout_in)   state_nxt = ST_NORMAL;
        else if (deb_hit_c) state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        // Ack wins over a coincident timeout.
        if (save_ack) begin
          state_nxt = ST_SHUTDOWN;
        end else if (tmo_hit_c) begin
          state_nxt        = ST_SHUTDOWN;
          save_timeout_nxt = 1'b1;
        end
      end
      ST_SHUTDOWN: begin
        if (rec_hit_c) state_nxt = ST_RESTART;
      end
      ST_RESTART: state_nxt = ST_NORMAL;
      default:    state_nxt = ST_NORMAL;
    endcase
    save_req_nxt   = (state_nxt == ST_SAVE);
    power_gate_nxt = (state_nxt == ST_SHUTDOWN);
    sys_reset_nxt  = (state_nxt == ST_SHUTDOWN) || (state_nxt == ST_RESTART);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_NORMAL;
      save_req     <= 1'b0;
      power_gate   <= 1'b0;
      sys_reset    <= 1'b0;
      save_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      save_req     <= save_req_nxt;
      power_gate   <= power_gate_nxt;
      sys_reset    <= sys_reset_nxt;
      save_timeout <= save_timeout_nxt;
    end
  end

`ifdef BROWNOUT_EVENT_CNT_EN
  // Saturating count of SAVE entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_count <= '0;
    end else if ((state_nxt == ST_SAVE) && (state != ST_SAVE) && (event_count != '1)) begin
      event_count <= event_count + CNT_W'(1);
    end
  end
`else
  assign event_count = '0;
`endif

endmodule

// File: tb/tb_brownout_handler.sv
// Directed self-checking bench for brownout_handler with default parameters.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_brownout_handler;

  localparam int unsigned CNT_W = 8;
`ifdef BROWNOUT_EVENT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             brownout_in;
  logic             save_ack;
  logic             save_req;
  logic             power_gate;
  logic             sys_reset;
  logic             save_timeout;
  logic [2:0]       state;
  logic [CNT_W-1:0] event_count;

  int n_checks = 0;
  int n_pass   = 0;

  brownout_handler #(
    .DEBOUNCE_CYCLES (4),
    .RECOVER_CYCLES  (16),
    .SAVE_TIMEOUT    (32),
    .CNT_W           (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .brownout_in  (brownout_in),
    .save_ack     (save_ack),
    .save_req     (save_req),
    .power_gate   (power_gate),
    .sys_reset    (sys_reset),
    .save_timeout (save_timeout),
    .state        (state),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int unsigned exp_evt(input int unsigned v);
    return CNT_EN ? ((v > 255) ? 255 : v) : 0;
  endfunction

  task automatic check_outs(input string tag, input int unsigned st, input int unsigned req,
                            input int unsigned pg, input int unsigned sr, input int unsigned to);
    check_eq({tag, ".state"}, state, st);
    check_eq({tag, ".save_req"}, save_req, req);
    check_eq({tag, ".power_gate"}, power_gate, pg);
    check_eq({tag, ".sys_reset"}, sys_reset, sr);
    check_eq({tag, ".save_timeout"}, save_timeout, to);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; brownout_in = 1'b0; save_ack = 1'b0;
    step(2);
    check_outs("reset", 0, 0, 0, 0, 0);
    check_eq("reset.event_count", event_count, 0);
    rst = 1'b0;

    // Held brownout, debounce latency, then full timeout.
    brownout_in = 1'b1;
    step(1);
    check_outs("deb1", 1, 0, 0, 0, 0);
    step(2);
    check_eq("deb3.save_req", save_req, 0);
    step(1);
    check_outs("deb4", 2, 1, 0, 0, 0);
    check_eq("deb4.event_count", event_count, exp_evt(1));
    brownout_in = 1'b0;
    n = 1;
    while (save_req && n < 100) begin
      step(1);
      if (save_req) n++;
    end
    check_eq("timeout.req_cycles", n, 32);
    check_outs("timeout.end", 3, 0, 1, 1, 1);

    // Recovery: 10 low, 1 high, 16 low.
    step(10);
    check_eq("rec10.state", state, 3);
    brownout_in = 1'b1;
    step(1);
    check_eq("rec_hi.power_gate", power_gate, 1);
    brownout_in = 1'b0;
    step(15);
    check_outs("rec15", 3, 0, 1, 1, 1);
    step(1);
    check_outs("rec16", 4, 0, 0, 1, 1);
    step(1);
    check_outs("restart_done", 0, 0, 0, 0, 1);

    // save_ack outside SAVE is ignored.
    save_ack = 1'b1;
    step(2);
    check_eq("ack_idle.state", state, 0);
    save_ack = 1'b0;
    do_reset();
    check_eq("rst.save_timeout", save_timeout, 0);

    // Short 3-cycle glitch does not commit.
    brownout_in = 1'b1;
    step(3);
    check_outs("glitch3", 1, 0, 0, 0, 0);
    brownout_in = 1'b0;
    step(1);
    check_outs("glitch_end", 0, 0, 0, 0, 0);
    step(4);
    check_eq("glitch.save_req", save_req, 0);
    check_eq("glitch.event_count", event_count, 0);

    // Ack after 5 cycles of save_req.
    brownout_in = 1'b1;
    step(4);
    check_eq("ack5.req_up", save_req, 1);
    brownout_in = 1'b0;
    step(4);
    check_eq("ack5.req_still", save_req, 1);
    save_ack = 1'b1;
    step(1);
    save_ack = 1'b0;
    check_outs("ack5", 3, 0, 1, 1, 0);
    check_eq("ack5.event_count", event_count, exp_evt(1));

    // Reset mid-SHUTDOWN.
    step(3);
    rst = 1'b1;
    step(1);
    check_outs("rst_shutdown", 0, 0, 0, 0, 0);
    check_eq("rst_shutdown.event_count", event_count, 0);
    rst = 1'b0;

    // Ack coincident with timeout: ack wins.
    brownout_in = 1'b1;
    step(4);
    brownout_in = 1'b0;
    step(31);
    check_eq("ack32.req_still", save_req, 1);
    save_ack = 1'b1;
    step(1);
    save_ack = 1'b0;
    check_outs("ack32", 3, 0, 1, 1, 0);

    // Event counter saturation over 300 events.
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      brownout_in = 1'b1;
      step(4);
      brownout_in = 1'b0;
      save_ack = 1'b1;
      step(1);
      save_ack = 1'b0;
      step(17);
      if (i == 255) check_eq("sat255.event_count", event_count, exp_evt(255));
    end
    check_eq("sat300.event_count", event_count, exp_evt(300));
    check_eq("sat300.state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/brownout_handler.md
# brownout_handler

Downstream consumer of the brownout detector output (`Brownout_tp`). It debounces the brownout flag, requests a state save from the system with a req/ack handshake bounded by a timeout, then holds the system power-gated and in reset. It releases the system only after the supply has stayed clean for a programmable recovery window. It also keeps a saturating count of committed brownout events for diagnostics.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive high `brownout_in` samples needed to commit a brownout. Must be ≥1.
- `RECOVER_CYCLES`, 16: consecutive low `brownout_in` samples in SHUTDOWN needed before release. Must be ≥1.
- `SAVE_TIMEOUT`, 32: maximum cycles spent in SAVE waiting for `save_ack`. Must be ≥1.
- `CNT_W`, 8: width of `event_count`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `brownout_in` in 1: brownout flag from the detector; sampled every edge.
- `save_ack` in 1: system acknowledges the state save is complete.
- `save_req` out 1: request to save state; high only in SAVE.
- `power_gate` out 1: high disconnects the load; high in SHUTDOWN.
- `sys_reset` out 1: system reset; high in SHUTDOWN and RESTART.
- `save_timeout` out 1: sticky flag; set when a SAVE ends by timeout.
- `state` out 3: current FSM state encoding, for debug.
- `event_count` out CNT_W: number of entries into SAVE, saturating.

## Operation
- FSM states: NORMAL=0, DEBOUNCE=1, SAVE=2, SHUTDOWN=3, RESTART=4.
- NORMAL:
  - `brownout_in`=1 → DEBOUNCE, run counter := 1.
  - If DEBOUNCE_CYCLES=1, go directly to SAVE instead.
- DEBOUNCE:
  - `brownout_in`=0 → NORMAL, counter cleared.
  - `brownout_in`=1 → counter +1; when the count reaches DEBOUNCE_CYCLES → SAVE.
- SAVE:
  - Entry increments `event_count`; it saturates at 2^CNT_W−1.
  - Timer clears on entry and counts cycles in SAVE.
  - `save_ack`=1 → SHUTDOWN.
  - Otherwise, timer reaching SAVE_TIMEOUT → SHUTDOWN and `save_timeout` := 1.
  - `brownout_in` is ignored in SAVE: the brownout is committed.
- SHUTDOWN:
  - Each low sample increments the recovery counter; any high sample clears it to 0.
  - Count reaching RECOVER_CYCLES → RESTART.
- RESTART: lasts exactly one cycle, then → NORMAL unconditionally. A brownout present at that point is picked up by NORMAL on the next edge.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state`.
- All counters are sized `$clog2(max param)+1` bits, so no counter wraps.

## Timing
- Reset values: state=NORMAL, `save_req`=0, `power_gate`=0, `sys_reset`=0, `save_timeout`=0, `event_count`=0, all internal counters 0.
- `rst` takes priority over every transition, from any state including mid-SAVE and mid-SHUTDOWN. It is the only clear for `save_timeout`.
- Debounce latency: if `brownout_in`=1 is sampled at edges k..k+DEBOUNCE_CYCLES−1, `save_req` rises after edge k+DEBOUNCE_CYCLES−1.
- `save_ack` sampled high at edge m: `save_req` falls and `power_gate`/`sys_reset` rise after edge m.
- `save_ack` arriving on the same cycle as the timeout: ack wins, and `save_timeout` stays 0.
- `save_ack` outside SAVE is ignored.
- Timeout: with `save_ack` held low, `save_req` is high for exactly SAVE_TIMEOUT cycles.
- Recovery: `power_gate` falls after the RECOVER_CYCLES-th consecutive low sample. `sys_reset` stays high one more cycle (RESTART), then falls.

## Configuration
- `BROWNOUT_EVENT_CNT_EN` defined: the `event_count` register and saturation logic are compiled in.
- Not defined: `event_count` is tied to 0 and no counter flops are generated. All other behaviour is identical.

## Structure
- Shared package `brownout_pkg` holds:
  - state encodings `ST_NORMAL` … `ST_RESTART` as 3-bit localparams;
  - the default parameter constants.
- One sub-module, `run_counter`: a consecutive-sample counter with clear, enable and a terminal-count compare. It is instantiated twice, once for debounce and once for recovery.
- The SAVE timer and the event counter are inline.

## Test plan
- Reset, then hold `brownout_in` high with defaults → `save_req` rises 4 cycles after the first high sample; `event_count`=1.
- Pulse `brownout_in` high for 3 cycles, then low → state returns to NORMAL; `save_req` never rises; `event_count`=0.
- In SAVE, raise `save_ack` after 5 cycles → next edge `power_gate`=1, `sys_reset`=1, `save_req`=0, `save_timeout`=0. Raise ack on exactly the 32nd cycle → `save_timeout` stays 0.
- In SAVE, keep `save_ack`=0 → `save_req` high for exactly 32 cycles, then SHUTDOWN with `save_timeout`=1 until `rst`.
- In SHUTDOWN, drive 10 low samples, 1 high, then 16 low → `power_gate` falls only after the 16-sample run; `sys_reset` falls 1 cycle later.
- Assert `rst` mid-SHUTDOWN → all outputs 0 and state NORMAL on the next edge. With the macro defined and 300 events injected (CNT_W=8) → `event_count` saturates at 255.
